rr_arb21: RTL and testbench

RR_ARB21 -- requirements
Module: rr_arb21

---
 rtl/rr_arb21.sv | 103 ++++++++++
 tb/tb_rr_arb21.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb21.sv
// rr_arb21: two-requester packet arbiter with round-robin priority.
// A requester owns the shared output for a whole packet (until a handshaked
// last beat); every packet is preceded by exactly one IDLE arbitration cycle.
// The data path is combinational in the owning states (zero-cycle latency).
module rr_arb21 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,

    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,

    output logic             c_valid,
    output logic [WIDTH-1:0] c_data,
    output logic             c_last,
    input  logic             c_ready,

    output logic [1:0]       grant
);

    localparam int unsigned GRANT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // prio_q: 0 = A favoured on contention, 1 = B favoured
    state_t state_q, state_d;
    logic   prio_q,  prio_d;

    // State and priority registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state, priority update and combinational output mux
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant   = GRANT_W'(0);
        c_valid = 1'b0;
        c_data  = a_data;
        c_last  = a_last;
        a_ready = 1'b0;
        b_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_valid && (!b_valid || !prio_q)) begin
                    state_d = OWN_A;
                end else if (b_valid) begin
                    state_d = OWN_B;
                end
            end

            OWN_A: begin
                grant   = 2'b01;
                c_valid = a_valid;
                c_data  = a_data;
                c_last  = a_last;
                a_ready = c_ready;
                // Leave only after the last beat has actually been taken
                if (a_valid && c_ready && a_last) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end

            OWN_B: begin
                grant   = 2'b10;
                c_valid = b_valid;
                c_data  = b_data;
                c_last  = b_last;
                b_ready = c_ready;
                if (b_valid && c_ready && b_last) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arb21.sv
// Directed bench for rr_arb21: per-cycle stimulus tables with hand-computed
// expected control vectors {grant, c_valid, a_ready, b_ready} and {c_last, c_data}.
module tb_rr_arb21;

    logic       clk;
    logic       rst;
    logic       a_valid, a_last, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [7:0] b_data;
    logic       c_valid, c_last, c_ready;
    logic [7:0] c_data;
    logic [1:0] grant;

    int n_cmp = 0;
    int n_err = 0;

    rr_arb21 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .c_valid (c_valid),
        .c_data  (c_data),
        .c_last  (c_last),
        .c_ready (c_ready),
        .grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle worth of inputs
    task automatic drive(input logic r, input logic av, input logic [7:0] ad, input logic al,
                         input logic bv, input logic [7:0] bd, input logic bl, input logic cr);
        rst     = r;
        a_valid = av;
        a_data  = ad;
        a_last  = al;
        b_valid = bv;
        b_data  = bd;
        b_last  = bl;
        c_ready = cr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'h88, 1'b0, 1'b1);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== 5'b00_000) begin
                n_err++;
                $display("FAIL reset ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, 5'b00_000);
            end
            n_cmp++;
            if ({c_last, c_data} !== 9'h177) begin
                n_err++;
                $display("FAIL reset idle_data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, 9'h177);
            end
            next_cycle();
        end
    endtask

    // Both valid, 3-beat packets each: A on cycles 2-4, IDLE 5, B on 6-8
    task automatic test_two_packets();
        logic       av [0:7];
        logic [7:0] ad [0:7];
        logic       al [0:7];
        logic [7:0] bd [0:7];
        logic       bl [0:7];
        logic [4:0] ec [0:7];
        logic [8:0] ed [0:7];
        av = '{1, 1, 1, 1, 0, 0, 0, 0};
        ad = '{8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00};
        al = '{0, 0, 0, 1, 0, 0, 0, 0};
        bd = '{8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hB2};
        bl = '{0, 0, 0, 0, 0, 0, 0, 1};
        ec = '{5'b00_000, 5'b01_110, 5'b01_110, 5'b01_110,
               5'b00_000, 5'b10_101, 5'b10_101, 5'b10_101};
        ed = '{9'h0A0, 9'h0A0, 9'h0A1, 9'h1A2, 9'h000, 9'h0B0, 9'h0B1, 9'h1B2};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, av[i], ad[i], al[i], 1'b1, bd[i], bl[i], 1'b1);
            @(negedge clk);
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== ec[i]) begin
                n_err++;
                $display("FAIL two_packets ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, ec[i]);
            end
            n_cmp++;
            if ({c_last, c_data} !== ed[i]) begin
                n_err++;
                $display("FAIL two_packets data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, ed[i]);
            end
            next_cycle();
        end
    endtask

    // Both continuously valid with single-beat packets: grant alternates
    task automatic test_alternate();
        logic [4:0] ec [0:7];
        logic [8:0] ed [0:7];
        int a_cnt = 0;
        int b_cnt = 0;
        ec = '{5'b00_000, 5'b01_110, 5'b00_000, 5'b10_101,
               5'b00_000, 5'b01_110, 5'b00_000, 5'b10_101};
        ed = '{9'h111, 9'h111, 9'h111, 9'h122, 9'h111, 9'h111, 9'h111, 9'h122};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
            @(negedge clk);
            if (a_valid && a_ready) a_cnt++;
            if (b_valid && b_ready) b_cnt++;
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== ec[i]) begin
                n_err++;
                $display("FAIL alternate ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, ec[i]);
            end
            n_cmp++;
            if ({c_last, c_data} !== ed[i]) begin
                n_err++;
                $display("FAIL alternate data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, ed[i]);
            end
            next_cycle();
        end
        n_cmp++;
        if (a_cnt != 2) begin
            n_err++;
            $display("FAIL alternate a_beats: got %0d want 2", a_cnt);
        end
        n_cmp++;
        if (b_cnt != 2) begin
            n_err++;
            $display("FAIL alternate b_beats: got %0d want 2", b_cnt);
        end
    endtask

    // OWN_A with c_ready low for 4 cycles: beat held, no ready, then completes
    task automatic test_stall();
        logic       cr [0:5];
        logic [4:0] ec [0:5];
        cr = '{0, 0, 0, 0, 0, 1};
        ec = '{5'b00_000, 5'b01_100, 5'b01_100, 5'b01_100, 5'b01_100, 5'b01_110};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, cr[i]);
            @(negedge clk);
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== ec[i]) begin
                n_err++;
                $display("FAIL stall ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, ec[i]);
            end
            n_cmp++;
            if ({c_last, c_data} !== 9'h15A) begin
                n_err++;
                $display("FAIL stall data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, 9'h15A);
            end
            next_cycle();
        end
    endtask

    // B owns (prio = 1 from A's last packet), 2-cycle b_valid gap while A waits
    task automatic test_gap();
        logic       bv [0:7];
        logic [7:0] bd [0:7];
        logic       bl [0:7];
        logic [4:0] ec [0:7];
        logic [8:0] ed [0:7];
        bv = '{1, 1, 0, 0, 1, 1, 0, 0};
        bd = '{8'hB4, 8'hB4, 8'hEE, 8'hEE, 8'hB5, 8'hB6, 8'h00, 8'h00};
        bl = '{0, 0, 0, 0, 0, 1, 0, 0};
        ec = '{5'b00_000, 5'b10_101, 5'b10_001, 5'b10_001,
               5'b10_101, 5'b10_101, 5'b00_000, 5'b01_110};
        ed = '{9'h133, 9'h0B4, 9'h0EE, 9'h0EE, 9'h0B5, 9'h1B6, 9'h133, 9'h133};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h33, 1'b1, bv[i], bd[i], bl[i], 1'b1);
            @(negedge clk);
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== ec[i]) begin
                n_err++;
                $display("FAIL gap ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, ec[i]);
            end
            n_cmp++;
            if ({c_last, c_data} !== ed[i]) begin
                n_err++;
                $display("FAIL gap data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, ed[i]);
            end
            next_cycle();
        end
    endtask

    // Reset during beat 2 of an A packet; prio was 1, so A winning the
    // following contended arbitration shows prio was cleared
    task automatic test_reset_mid();
        logic       rs [0:6];
        logic       av [0:6];
        logic [7:0] ad [0:6];
        logic       al [0:6];
        logic       bv [0:6];
        logic [4:0] ec [0:6];
        logic [8:0] ed [0:6];
        rs = '{0, 0, 1, 0, 0, 0, 0};
        av = '{1, 1, 1, 1, 1, 0, 0};
        ad = '{8'hC0, 8'hC0, 8'hC1, 8'hD0, 8'hD0, 8'h00, 8'h00};
        al = '{0, 0, 0, 1, 1, 0, 0};
        bv = '{0, 0, 0, 1, 1, 1, 1};
        ec = '{5'b00_000, 5'b01_110, 5'b01_110, 5'b00_000,
               5'b01_110, 5'b00_000, 5'b10_101};
        ed = '{9'h0C0, 9'h0C0, 9'h0C1, 9'h1D0, 9'h1D0, 9'h000, 9'h1E0};
        for (int i = 0; i < 7; i++) begin
            drive(rs[i], av[i], ad[i], al[i], bv[i], 8'hE0, 1'b1, 1'b1);
            @(negedge clk);
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== ec[i]) begin
                n_err++;
                $display("FAIL reset_mid ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, ec[i]);
            end
            n_cmp++;
            if ({c_last, c_data} !== ed[i]) begin
                n_err++;
                $display("FAIL reset_mid data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, ed[i]);
            end
            next_cycle();
        end
    endtask

    // Only B valid with prio = 0: B granted directly; afterwards A wins contention
    task automatic test_only_b();
        logic       av [0:4];
        logic [7:0] ad [0:4];
        logic       al [0:4];
        logic       bv [0:4];
        logic [7:0] bd [0:4];
        logic       bl [0:4];
        logic [4:0] ec [0:4];
        logic [8:0] ed [0:4];
        av = '{0, 0, 0, 1, 1};
        ad = '{8'h00, 8'h00, 8'h00, 8'hF8, 8'hF8};
        al = '{0, 0, 0, 1, 1};
        bv = '{1, 1, 1, 1, 0};
        bd = '{8'hF0, 8'hF0, 8'hF1, 8'hF2, 8'hF2};
        bl = '{0, 0, 1, 1, 1};
        ec = '{5'b00_000, 5'b10_101, 5'b10_101, 5'b00_000, 5'b01_110};
        ed = '{9'h000, 9'h0F0, 9'h1F1, 9'h1F8, 9'h1F8};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, av[i], ad[i], al[i], bv[i], bd[i], bl[i], 1'b1);
            @(negedge clk);
            n_cmp++;
            if ({grant, c_valid, a_ready, b_ready} !== ec[i]) begin
                n_err++;
                $display("FAIL only_b ctrl cycle %0d: got %b want %b", i + 1,
                         {grant, c_valid, a_ready, b_ready}, ec[i]);
            end
            n_cmp++;
            if ({c_last, c_data} !== ed[i]) begin
                n_err++;
                $display("FAIL only_b data cycle %0d: got %h want %h", i + 1,
                         {c_last, c_data}, ed[i]);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_two_packets();
        test_alternate();
        test_stall();
        test_gap();
        test_reset_mid();
        test_only_b();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
